// File: rtl/ad9958_pkg.sv
// rtl/ad9958_pkg.sv - lane-mode encoding, state encoding and lane helper for the AD9958 serial master
package ad9958_pkg;

    localparam logic [1:0] MODE_1B  = 2'd0;
    localparam logic [1:0] MODE_2B  = 2'd1;
    localparam logic [1:0] MODE_4B  = 2'd2;
    localparam logic [1:0] MODE_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO
    } state_t;

    function automatic logic [2:0] lanes_of(input logic [1:0] mode);
        case (mode)
            MODE_2B: lanes_of = 3'd2;
            MODE_4B: lanes_of = 3'd4;
            default: lanes_of = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ad9958_serial_master_sclk_gen.sv
// rtl/ad9958_serial_master_sclk_gen.sv - CLK_DIV phase divider, ticks on the last clock of each sclk half-period
module ad9958_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] RELOAD = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = RELOAD;
        end else if (enable_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - W'(1);
        end
    end

    assign tick_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/ad9958_serial_master.sv
// rtl/ad9958_serial_master.sv - frames one MSB-first word onto 1/2/4 SDIO lanes with CS_N and divided SCLK
module ad9958_serial_master
    import ad9958_pkg::*;
#(
    parameter int MAX_BITS = 64,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    nbits,
    input  logic [MAX_BITS-1:0] data,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                cs_n,
    output logic                sclk,
    output logic [3:0]          sdio
);

    state_t                state_q, state_d;
    logic [MAX_BITS-1:0]   sh_q, sh_d;
    logic [1:0]            mode_q, mode_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic [3:0]            sdio_q, sdio_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  restart;
    logic                  tick;
    logic                  legal;
    logic [CNT_W-1:0]      sym_total;
    logic [MAX_BITS-1:0]   aligned;
    logic [MAX_BITS-1:0]   shifted;

    // Symbol currently at the top of an MSB-aligned word; padding zeros come from the shift.
    function automatic logic [3:0] head(input logic [MAX_BITS-1:0] v, input logic [1:0] m);
        case (m)
            MODE_2B: head = {2'b00, v[MAX_BITS-1 -: 2]};
            MODE_4B: head = v[MAX_BITS-1 -: 4];
            default: head = {3'b000, v[MAX_BITS-1]};
        endcase
    endfunction

    assign legal   = (nbits != '0) && (nbits <= CNT_W'(MAX_BITS)) && (mode != MODE_BAD);
    assign aligned = data << (CNT_W'(MAX_BITS) - nbits);
    assign shifted = sh_q << lanes_of(mode_q);

    always_comb begin
        case (mode)
            MODE_2B: sym_total = (nbits >> 1) + CNT_W'(nbits[0]);
            MODE_4B: sym_total = (nbits >> 2) + CNT_W'(|nbits[1:0]);
            default: sym_total = nbits;
        endcase
    end

    ad9958_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .restart_i (restart),
        .enable_i  (busy),
        .tick_o    (tick)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            mode_q    <= MODE_1B;
            cnt_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdio_q    <= 4'b0000;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdio_q    <= sdio_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdio_d    = sdio_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                sdio_d = 4'b0000;
                if (start) begin
                    if (legal) begin
                        restart = 1'b1;
                        state_d = ST_SETUP;
                        sh_d    = aligned;
                        mode_d  = mode;
                        cnt_d   = sym_total;
                        cs_n_d  = 1'b0;
                        sdio_d  = head(aligned, mode);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT_HI;
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (tick) begin
                    state_d = ST_SHIFT_LO;
                    sclk_d  = 1'b0;
                    cnt_d   = cnt_q - CNT_W'(1);
                    // The last symbol stays on the lanes through the final low phase.
                    if (cnt_q > CNT_W'(1)) begin
                        sh_d   = shifted;
                        sdio_d = head(shifted, mode_q);
                    end
                end
            end
            ST_SHIFT_LO: begin
                if (tick) begin
                    if (cnt_q != '0) begin
                        state_d = ST_SHIFT_HI;
                        sclk_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        sdio_d  = 4'b0000;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign cs_n    = cs_n_q;
    assign sclk    = sclk_q;
    assign sdio    = sdio_q;

endmodule

// File: tb/tb_ad9958_serial_master.sv
// tb/tb_ad9958_serial_master.sv - directed bench with a per-cycle frame model for two divider settings
module tb_ad9958_serial_master;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        d0_start, d1_start;
    logic [1:0]  d0_mode, d1_mode;
    logic [6:0]  d0_nbits, d1_nbits;
    logic [63:0] d0_data, d1_data;
    logic        d0_busy, d0_done, d0_cfg_err, d0_cs_n, d0_sclk;
    logic        d1_busy, d1_done, d1_cfg_err, d1_cs_n, d1_sclk;
    logic [3:0]  d0_sdio, d1_sdio;

    ad9958_serial_master #(.MAX_BITS(64), .CLK_DIV(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(d0_start), .mode(d0_mode),
        .nbits(d0_nbits), .data(d0_data), .busy(d0_busy), .done(d0_done),
        .cfg_err(d0_cfg_err), .cs_n(d0_cs_n), .sclk(d0_sclk), .sdio(d0_sdio)
    );

    ad9958_serial_master #(.MAX_BITS(64), .CLK_DIV(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(d1_start), .mode(d1_mode),
        .nbits(d1_nbits), .data(d1_data), .busy(d1_busy), .done(d1_done),
        .cfg_err(d1_cfg_err), .cs_n(d1_cs_n), .sclk(d1_sclk), .sdio(d1_sdio)
    );

    int n_chk = 0;
    int n_err = 0;

    int          n_busy[2], n_done[2], n_cfg[2], n_csl[2], rises[2], cap_w[2];
    logic [63:0] cap[2];
    logic        prev_sclk[2];

    // Frame model: a frame is described only by its start cycle, divider, symbol list and length.
    bit m_valid = 1'b0;
    bit m_act[2], m_cerr[2];
    int m_k[2], m_len[2], m_s[2];
    int m_syms[2][64];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor(int d, logic busy, logic done, logic cfg, logic cs_n, logic sclk,
                           logic [3:0] sdio);
        logic [3:0] mask;
        mask = (cap_w[d] == 4) ? 4'hF : (cap_w[d] == 2) ? 4'h3 : 4'h1;
        if (busy === 1'b1) n_busy[d]++;
        if (done === 1'b1) n_done[d]++;
        if (cfg === 1'b1) n_cfg[d]++;
        if (cs_n === 1'b0) n_csl[d]++;
        if (sclk === 1'b1 && prev_sclk[d] !== 1'b1) begin
            rises[d]++;
            cap[d] = (cap[d] << cap_w[d]) | 64'(sdio & mask);
        end
        prev_sclk[d] = sclk;
    endtask

    function automatic logic [8:0] model_out(int d, int cd);
        int ph, idx;
        if (m_act[d] && m_k[d] < m_len[d]) begin
            ph  = m_k[d] / cd;
            idx = ph / 2;
            if (idx > m_s[d] - 1) idx = m_s[d] - 1;
            return {1'b1, 1'b0, m_cerr[d], 1'b0, (ph % 2 == 1), 4'(m_syms[d][idx])};
        end else if (m_act[d] && m_k[d] == m_len[d]) begin
            return {1'b0, 1'b1, m_cerr[d], 1'b1, 1'b0, 4'b0000};
        end
        return {1'b0, 1'b0, m_cerr[d], 1'b1, 1'b0, 4'b0000};
    endfunction

    task automatic advance(int d, int cd, logic rst_n, logic st, logic [1:0] md, int nb,
                           logic [63:0] dat);
        int lanes, pos, v;
        m_cerr[d] = 1'b0;
        if (!rst_n) begin
            m_act[d] = 1'b0;
        end else if (m_act[d] && m_k[d] < m_len[d]) begin
            m_k[d]++;
        end else begin
            m_act[d] = 1'b0;
            if (st) begin
                if (nb >= 1 && nb <= 64 && md != 2'd3) begin
                    lanes  = 1 << md;
                    m_s[d] = (nb + lanes - 1) / lanes;
                    for (int i = 0; i < m_s[d]; i++) begin
                        v = 0;
                        for (int j = 0; j < lanes; j++) begin
                            pos = nb - 1 - (i * lanes + (lanes - 1 - j));
                            if (pos >= 0 && dat[pos]) v += (1 << j);
                        end
                        m_syms[d][i] = v;
                    end
                    m_len[d] = cd * (1 + 2 * m_s[d]);
                    m_k[d]   = 0;
                    m_act[d] = 1'b1;
                end else begin
                    m_cerr[d] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                monitor(0, d0_busy, d0_done, d0_cfg_err, d0_cs_n, d0_sclk, d0_sdio);
                monitor(1, d1_busy, d1_done, d1_cfg_err, d1_cs_n, d1_sclk, d1_sdio);
                chk("model_d0", 64'({d0_busy, d0_done, d0_cfg_err, d0_cs_n, d0_sclk, d0_sdio}),
                    64'(model_out(0, 2)));
                chk("model_d1", 64'({d1_busy, d1_done, d1_cfg_err, d1_cs_n, d1_sclk, d1_sdio}),
                    64'(model_out(1, 1)));
            end
            advance(0, 2, reset_n, d0_start, d0_mode, int'(d0_nbits), d0_data);
            advance(1, 1, reset_n, d1_start, d1_mode, int'(d1_nbits), d1_data);
            m_valid = 1'b1;
        end
    end

    task automatic set_in(int d, logic st, logic [1:0] md, int nb, logic [63:0] dat);
        if (d == 0) begin
            d0_start = st; d0_mode = md; d0_nbits = 7'(nb); d0_data = dat;
        end else begin
            d1_start = st; d1_mode = md; d1_nbits = 7'(nb); d1_data = dat;
        end
    endtask

    task automatic clear(int d, int w);
        n_busy[d] = 0; n_done[d] = 0; n_cfg[d] = 0; n_csl[d] = 0;
        rises[d] = 0; cap[d] = '0; cap_w[d] = w;
    endtask

    task automatic wait_done(int d, int target);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock); #1;
            if (n_done[d] >= target) return;
        end
        chk("timeout_done", 64'(n_done[d]), 64'(target));
    endtask

    task automatic wait_rises(int d, int target);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock); #1;
            if (rises[d] >= target) return;
        end
        chk("timeout_rises", 64'(rises[d]), 64'(target));
    endtask

    task automatic run(int d, logic [1:0] md, int nb, logic [63:0] dat);
        @(posedge clock); #1;
        set_in(d, 1'b1, md, nb, dat);
        @(posedge clock); #1;
        set_in(d, 1'b0, 2'd3, 0, 64'hDEAD_BEEF_0BAD_F00D);
        wait_done(d, 1);
        repeat (3) @(negedge clock);
        #1;
    endtask

    task automatic pulse_bad(int d, logic [1:0] md, int nb);
        @(posedge clock); #1;
        set_in(d, 1'b1, md, nb, 64'h55);
        @(posedge clock); #1;
        set_in(d, 1'b0, 2'd0, 8, 64'h55);
        repeat (2) @(posedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 1'b0, 2'd0, 0, 64'h0);
        set_in(1, 1'b0, 2'd0, 0, 64'h0);
        clear(0, 1);
        clear(1, 1);
        prev_sclk[0] = 1'b0;
        prev_sclk[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", 64'({d0_busy, d0_done, d0_cfg_err, d0_cs_n, d0_sclk, d0_sdio}),
            64'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000}));
        reset_n = 1'b1;

        clear(0, 1);
        run(0, 2'd0, 8, 64'hA5);
        chk("t1_bits", cap[0], 64'hA5);
        chk("t1_rises", 64'(rises[0]), 64'd8);
        chk("t1_busy", 64'(n_busy[0]), 64'd34);
        chk("t1_done", 64'(n_done[0]), 64'd1);

        clear(1, 4);
        run(1, 2'd2, 24, 64'h123456);
        chk("t2_syms", cap[1], 64'h123456);
        chk("t2_busy", 64'(n_busy[1]), 64'd13);

        clear(0, 2);
        run(0, 2'd1, 5, 64'h1B);
        chk("t3_syms", cap[0], 64'b110110);
        chk("t3_rises", 64'(rises[0]), 64'd3);

        clear(0, 1);
        pulse_bad(0, 2'd0, 0);
        pulse_bad(0, 2'd0, 65);
        pulse_bad(0, 2'd3, 8);
        chk("t4_cfg_err", 64'(n_cfg[0]), 64'd3);
        chk("t4_cs_low", 64'(n_csl[0]), 64'd0);
        chk("t4_busy", 64'(n_busy[0]), 64'd0);

        clear(0, 1);
        @(posedge clock); #1;
        set_in(0, 1'b1, 2'd0, 8, 64'hFF);
        @(posedge clock); #1;
        set_in(0, 1'b0, 2'd0, 8, 64'hFF);
        wait_rises(0, 3);
        @(posedge clock); #1;
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("t5_rst_outs", 64'({d0_busy, d0_cs_n, d0_sclk, d0_sdio}),
            64'({1'b0, 1'b1, 1'b0, 4'b0000}));
        reset_n = 1'b1;
        repeat (6) @(posedge clock);
        chk("t5_no_done", 64'(n_done[0]), 64'd0);
        clear(0, 1);
        run(0, 2'd0, 8, 64'hA5);
        chk("t5_clean_bits", cap[0], 64'hA5);
        chk("t5_clean_done", 64'(n_done[0]), 64'd1);

        clear(0, 1);
        @(posedge clock); #1;
        set_in(0, 1'b1, 2'd0, 4, 64'h9);
        wait_done(0, 1);
        chk("t6_gap_cs_n", 64'(d0_cs_n), 64'd1);
        @(posedge clock); #1;
        chk("t6_next_frame", 64'({d0_cs_n, d0_busy}), 64'b01);
        set_in(0, 1'b0, 2'd0, 4, 64'h9);
        @(posedge clock); #1;
        set_in(0, 1'b1, 2'd3, 0, 64'h0);
        @(posedge clock); #1;
        set_in(0, 1'b0, 2'd0, 4, 64'h0);
        wait_done(0, 2);
        repeat (3) @(negedge clock);
        #1;
        chk("t6_bits", cap[0], 64'h99);
        chk("t6_done", 64'(n_done[0]), 64'd2);
        chk("t6_busy", 64'(n_busy[0]), 64'd36);
        chk("t6_no_cfg", 64'(n_cfg[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
